// File: rtl/cwru_tx_pkg.sv
// Shared types and elaboration helpers for the CW/RU transmit framer.
package cwru_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    START,
    DATA,
    PAR,
    STOP
  } tx_state_t;

  function automatic int calc_div(input int clk_hz, input int bit_hz);
    return clk_hz / bit_hz;
  endfunction

  function automatic int frame_len(input int pre_len, input int data_w,
                                   input int parity_en, input int stop_bits);
    return pre_len + 1 + data_w + parity_en + stop_bits;
  endfunction

  // Preamble alternates 1,0,1,0... starting with bit 0 = 1.
  function automatic logic pre_bit(input int k);
    return (k % 2) == 0;
  endfunction

endpackage

// File: rtl/cwru_tx_framer_if.sv
// Code-word handshake between the word source and the framer.
interface cwru_tx_framer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/cwru_bit_timer.sv
// Bit-period clock-enable divider; runs only while the framer is busy.
module cwru_bit_timer
  import cwru_tx_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BIT_HZ = 4000
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic run,
  output logic bit_tick,
  output logic first_half
);
  localparam int DIV = calc_div(CLK_HZ, BIT_HZ);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2);

  if (DIV < 2) begin : g_bad_div
    $error("cwru_bit_timer: CLK_HZ/BIT_HZ must be at least 2");
  end

  logic [CW-1:0] div_reg, div_next;

  always_comb begin
    div_next = div_reg + 1'b1;
    if (!run || div_reg == LAST) begin
      div_next = '0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_next;
    end
  end

  assign bit_tick   = run & (div_reg == LAST);
  assign first_half = run & (div_reg < HALF);

endmodule

// File: rtl/cwru_tx_framer.sv
// Serialises a held code word as preamble/start/data/parity/stop on one line,
// optionally repeating frames back-to-back while repeat_en is high.
module cwru_tx_framer
  import cwru_tx_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BIT_HZ     = 4000,
  parameter int DATA_W     = 8,
  parameter int PRE_LEN    = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                   CLOCK_50,
  input  logic                   RESET_N,
  cwru_tx_framer_if.slave        word_in,
  input  logic                   repeat_en,
  output logic                   tx_line,
  output logic                   tx_clk,
  output logic                   busy,
  output logic                   frame_done
);
  localparam logic [5:0] PRE_LAST   = 6'((PRE_LEN > 0) ? PRE_LEN - 1 : 0);
  localparam logic [5:0] DATA_LAST  = 6'(DATA_W - 1);
  localparam logic [5:0] STOP_LAST  = 6'(STOP_BITS - 1);
  localparam tx_state_t  FIRST_STATE = (PRE_LEN > 0) ? PRE : START;
  localparam logic       PAR_INV    = (PARITY_ODD != 0);

  if (DATA_W < 1 || DATA_W > 32) begin : g_bad_data_w
    $error("cwru_tx_framer: DATA_W must be 1..32");
  end
  if (PRE_LEN < 0 || PRE_LEN > 32) begin : g_bad_pre_len
    $error("cwru_tx_framer: PRE_LEN must be 0..32");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("cwru_tx_framer: STOP_BITS must be 1 or 2");
  end

  tx_state_t         state_reg, state_next;
  logic [5:0]        bit_reg, bit_next;
  logic [DATA_W-1:0] held_reg, held_next;
  logic [31:0]       held_ext;
  logic              run, bit_tick, first_half, par_bit;

  assign run      = (state_reg != IDLE);
  assign held_ext = 32'(held_reg);
  assign par_bit  = (^held_reg) ^ PAR_INV;

  cwru_bit_timer #(
    .CLK_HZ (CLK_HZ),
    .BIT_HZ (BIT_HZ)
  ) u_bit_timer (
    .CLOCK_50   (CLOCK_50),
    .RESET_N    (RESET_N),
    .run        (run),
    .bit_tick   (bit_tick),
    .first_half (first_half)
  );

  always_comb begin
    state_next = state_reg;
    bit_next   = bit_reg;
    held_next  = held_reg;
    tx_line    = 1'b1;
    frame_done = 1'b0;
    case (state_reg)
      IDLE: begin
        if (word_in.in_valid) begin
          held_next  = word_in.in_data;
          bit_next   = '0;
          state_next = FIRST_STATE;
        end
      end
      PRE: begin
        tx_line = pre_bit(int'(bit_reg));
        if (bit_tick) begin
          if (bit_reg == PRE_LAST) begin
            bit_next   = '0;
            state_next = START;
          end else begin
            bit_next = bit_reg + 6'd1;
          end
        end
      end
      START: begin
        tx_line = 1'b0;
        if (bit_tick) begin
          bit_next   = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        tx_line = held_ext[bit_reg[4:0]];
        if (bit_tick) begin
          if (bit_reg == DATA_LAST) begin
            bit_next   = '0;
            state_next = (PARITY_EN != 0) ? PAR : STOP;
          end else begin
            bit_next = bit_reg + 6'd1;
          end
        end
      end
      PAR: begin
        tx_line = par_bit;
        if (bit_tick) begin
          bit_next   = '0;
          state_next = STOP;
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (bit_reg == STOP_LAST) begin
            // repeat_en is only looked at here, so mid-frame changes finish the frame
            frame_done = 1'b1;
            bit_next   = '0;
            state_next = repeat_en ? FIRST_STATE : IDLE;
          end else begin
            bit_next = bit_reg + 6'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg <= IDLE;
      bit_reg   <= '0;
      held_reg  <= '0;
    end else begin
      state_reg <= state_next;
      bit_reg   <= bit_next;
      held_reg  <= held_next;
    end
  end

  assign word_in.in_ready = (state_reg == IDLE);
  assign busy             = run;
  assign tx_clk           = first_half;

endmodule

// File: tb/tb_cwru_tx_framer.sv
// Directed bench for cwru_tx_framer: three parameterisations sharing one clock.
module tb_cwru_tx_framer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rep_a = 1'b0;
  logic rep_b = 1'b0;
  logic rep_c = 1'b0;
  logic line_a, tclk_a, busy_a, done_a;
  logic line_b, tclk_b, busy_b, done_b;
  logic line_c, tclk_c, busy_c, done_c;

  int checks   = 0;
  int failures = 0;
  int sel      = 0;

  logic line_s, tclk_s, busy_s, done_s, ready_s;
  logic [127:0] lv, cv, bv, dv, rv;

  cwru_tx_framer_if #(.DATA_W(8)) if_a ();
  cwru_tx_framer_if #(.DATA_W(8)) if_b ();
  cwru_tx_framer_if #(.DATA_W(8)) if_c ();

  // DIV=4, even parity
  cwru_tx_framer #(
    .CLK_HZ(16), .BIT_HZ(4), .DATA_W(8), .PRE_LEN(8),
    .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
  ) dut_a (
    .CLOCK_50(clk), .RESET_N(rst_n), .word_in(if_a), .repeat_en(rep_a),
    .tx_line(line_a), .tx_clk(tclk_a), .busy(busy_a), .frame_done(done_a)
  );

  // DIV=4, odd parity
  cwru_tx_framer #(
    .CLK_HZ(16), .BIT_HZ(4), .DATA_W(8), .PRE_LEN(8),
    .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)
  ) dut_b (
    .CLOCK_50(clk), .RESET_N(rst_n), .word_in(if_b), .repeat_en(rep_b),
    .tx_line(line_b), .tx_clk(tclk_b), .busy(busy_b), .frame_done(done_b)
  );

  // DIV=5, no parity
  cwru_tx_framer #(
    .CLK_HZ(20), .BIT_HZ(4), .DATA_W(8), .PRE_LEN(8),
    .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
  ) dut_c (
    .CLOCK_50(clk), .RESET_N(rst_n), .word_in(if_c), .repeat_en(rep_c),
    .tx_line(line_c), .tx_clk(tclk_c), .busy(busy_c), .frame_done(done_c)
  );

  always #5 clk = ~clk;

  always_comb begin
    line_s  = line_a;
    tclk_s  = tclk_a;
    busy_s  = busy_a;
    done_s  = done_a;
    ready_s = if_a.in_ready;
    if (sel == 1) begin
      line_s  = line_b;
      tclk_s  = tclk_b;
      busy_s  = busy_b;
      done_s  = done_b;
      ready_s = if_b.in_ready;
    end else if (sel == 2) begin
      line_s  = line_c;
      tclk_s  = tclk_c;
      busy_s  = busy_c;
      done_s  = done_c;
      ready_s = if_c.in_ready;
    end
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Each frame bit (bit k of fb) held for div cycles, cycle j of the frame at index j.
  function automatic logic [127:0] stretch(input logic [31:0] fb, input int nbits, input int div);
    logic [127:0] v;
    v = '0;
    for (int b = 0; b < nbits; b++)
      for (int c = 0; c < div; c++)
        v[b*div + c] = fb[b];
    return v;
  endfunction

  function automatic logic [127:0] clk_pat(input int nbits, input int div);
    logic [127:0] v;
    v = '0;
    for (int b = 0; b < nbits; b++)
      for (int c = 0; c < div; c++)
        v[b*div + c] = (c < div / 2);
    return v;
  endfunction

  function automatic logic [127:0] ones(input int n);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [127:0] one_at(input int i);
    logic [127:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic drive(input logic v, input logic [7:0] d);
    case (sel)
      1:       begin if_b.in_valid = v; if_b.in_data = d; end
      2:       begin if_c.in_valid = v; if_c.in_data = d; end
      default: begin if_a.in_valid = v; if_a.in_data = d; end
    endcase
  endtask

  task automatic accept_word(input logic [7:0] w);
    @(negedge clk);
    check_eq("ready_at_accept", ready_s, 1'b1);
    drive(1'b1, w);
    @(posedge clk);
    #1;
    drive(1'b0, w);
    $display("accept dut=%0d word=%02h t=%0t", sel, w, $time);
  endtask

  task automatic capture(input int n);
    lv = '0; cv = '0; bv = '0; dv = '0; rv = '0;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      lv[j] = line_s;
      cv[j] = tclk_s;
      bv[j] = busy_s;
      dv[j] = done_s;
      rv[j] = ready_s;
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check_eq({tag, "_busy"},  busy_s,  1'b0);
    check_eq({tag, "_ready"}, ready_s, 1'b1);
    check_eq({tag, "_done"},  done_s,  1'b0);
    check_eq({tag, "_tclk"},  tclk_s,  1'b0);
    check_eq({tag, "_line"},  line_s,  1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    int dcount;
    if_a.in_valid = 1'b0; if_a.in_data = '0;
    if_b.in_valid = 1'b0; if_b.in_data = '0;
    if_c.in_valid = 1'b0; if_c.in_data = '0;

    repeat (3) @(negedge clk);
    check_eq("rst_line", line_a, 1'b1);
    check_eq("rst_tclk", tclk_a, 1'b0);
    check_eq("rst_busy", busy_a, 1'b0);
    check_eq("rst_done", done_a, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", if_a.in_ready, 1'b1);

    // A5, even parity: frame word 19'h54A55, 76 cycles
    sel = 0;
    accept_word(8'hA5);
    capture(76);
    check_eq("a5_line",  lv, stretch(32'h54A55, 19, 4));
    check_eq("a5_tclk",  cv, clk_pat(19, 4));
    check_eq("a5_busy",  bv, ones(76));
    check_eq("a5_done",  dv, one_at(75));
    check_eq("a5_ready", rv, '0);
    check_idle("a5_after");
    $display("frame dut=a word=a5 t=%0t", $time);

    // 07, odd parity: parity bit 0, frame word 19'h40E55
    sel = 1;
    accept_word(8'h07);
    capture(76);
    check_eq("b07_line", lv, stretch(32'h40E55, 19, 4));
    check_eq("b07_done", dv, one_at(75));
    check_idle("b07_after");
    $display("frame dut=b word=07 t=%0t", $time);

    // C3, no parity, DIV=5: 18 bits x 5 = 90 cycles, frame word 18'h38655
    sel = 2;
    accept_word(8'hC3);
    capture(90);
    check_eq("c_line", lv, stretch(32'h38655, 18, 5));
    check_eq("c_tclk", cv, clk_pat(18, 5));
    check_eq("c_busy", bv, ones(90));
    check_eq("c_done", dv, one_at(89));
    check_idle("c_after");
    $display("frame dut=c word=c3 t=%0t", $time);

    // Repeat 3C three times, dropping repeat_en during frame 3
    sel = 0;
    rep_a = 1'b1;
    accept_word(8'h3C);
    for (int f = 0; f < 3; f++) begin
      if (f == 2) begin
        fork
          begin
            repeat (40) @(negedge clk);
            rep_a = 1'b0;
          end
        join_none
      end
      capture(76);
      check_eq($sformatf("rep%0d_line", f), lv, stretch(32'h47855, 19, 4));
      check_eq($sformatf("rep%0d_busy", f), bv, ones(76));
      check_eq($sformatf("rep%0d_done", f), dv, one_at(75));
      check_eq($sformatf("rep%0d_ready", f), rv, '0);
      $display("frame dut=a word=3c repeat=%0d t=%0t", f, $time);
    end
    check_idle("rep_after");

    // in_valid held high; data changes after acceptance must not matter
    @(negedge clk);
    drive(1'b1, 8'h5A);
    @(posedge clk);
    #1;
    if_a.in_data = 8'hFF;
    capture(76);
    check_eq("hold_line", lv, stretch(32'h4B455, 19, 4));
    check_eq("hold_done", dv, one_at(75));
    @(negedge clk);
    check_eq("hold_gap_busy",  busy_s,  1'b0);
    check_eq("hold_gap_ready", ready_s, 1'b1);
    @(posedge clk);
    #1;
    drive(1'b0, 8'hFF);
    capture(76);
    check_eq("hold2_line", lv, stretch(32'h5FE55, 19, 4));
    check_eq("hold2_done", dv, one_at(75));
    check_idle("hold2_after");
    $display("frame dut=a word=5a then ff t=%0t", $time);

    // Reset mid-DATA: 81 at frame cycle 42 is data bit 1 (=0), tx_clk high
    accept_word(8'h81);
    repeat (42) @(negedge clk);
    check_eq("pre_rst_busy", busy_a, 1'b1);
    check_eq("pre_rst_line", line_a, 1'b0);
    check_eq("pre_rst_tclk", tclk_a, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_line", line_a, 1'b1);
    check_eq("mid_rst_tclk", tclk_a, 1'b0);
    check_eq("mid_rst_busy", busy_a, 1'b0);
    dcount = (done_a === 1'b1) ? 1 : 0;
    repeat (3) begin
      @(negedge clk);
      if (done_a === 1'b1) dcount++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ready", if_a.in_ready, 1'b1);
    check_eq("post_rst_busy",  busy_a,        1'b0);
    repeat (80) begin
      @(negedge clk);
      if (done_a === 1'b1) dcount++;
    end
    check_eq("rst_no_done", dcount, 0);
    $display("reset abort dut=a word=81 t=%0t", $time);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
